// File: rtl/sdram_pkg.sv
// Shared types and constants for the SDRAM request queue and its FIFO.
package sdram_pkg;

  typedef enum logic [1:0] {
    D_IDLE  = 2'd0,
    D_ISSUE = 2'd1,
    D_WAIT  = 2'd2
  } disp_state_e;

  localparam logic [1:0] SDRAM_WINDOW     = 2'b10;
  localparam int         CTRL_LAT_DEFAULT = 5;
  localparam int         REQ_W            = 65;

  // Bus address layout as seen by the controller.
  typedef struct packed {
    logic [1:0]  window;
    logic [4:0]  rsvd;
    logic [8:0]  col;
    logic [1:0]  bank;
    logic [13:0] row;
  } sdram_addr_t;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  function automatic logic in_window(input logic [31:0] addr);
    sdram_addr_t a;
    a = sdram_addr_t'(addr);
    return a.window == SDRAM_WINDOW;
  endfunction

endpackage

// File: rtl/sdram_req_fifo.sv
// In-order request FIFO; the head entry is visible combinationally for the dispatcher.
module sdram_req_fifo
  import sdram_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [REQ_W-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [REQ_W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [REQ_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // Full is taken from the registered count, so a same-cycle pop never frees a slot.
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sdram_req_queue.sv
// Bus-side request queue: buffers single-beat requests and dispatches them one
// at a time to the SDRAM command controller, returning responses in order.
//
// state   | meaning
// D_IDLE  | waiting for a queued request; pops the head into the hold registers
// D_ISSUE | one-cycle controller strobe with held address/data
// D_WAIT  | controller busy; count until completion or timeout
module sdram_req_queue
  import sdram_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int CTRL_LAT = CTRL_LAT_DEFAULT,
  parameter int TIMEOUT  = 15
) (
  input  logic        in_HCLK,
  input  logic        in_HRESET,
  input  logic        in_HSEL,
  input  logic        in_HWRITE,
  input  logic [31:0] in_HADDR,
  input  logic [31:0] in_HWDATA,
  output logic        out_HREADY,
  output logic [31:0] out_HRDATA,
  output logic        out_rvalid,
  output logic        out_wdone,
  output logic        out_err_addr,
  output logic        out_err_timeout,
  output logic        out_ctrl_HSEL,
  output logic        out_ctrl_HWRITE,
  output logic [31:0] out_ctrl_HADDR,
  output logic [31:0] out_ctrl_HWDATA,
  input  logic        in_ctrl_HREADY,
  input  logic [31:0] in_ctrl_HRDATA
);

  localparam int CW = $clog2(TIMEOUT + 1);

  disp_state_e  state;
  logic [CW-1:0] cnt;
  logic         fifo_full;
  logic         fifo_empty;
  logic         fifo_push;
  logic         fifo_pop;
  req_t         fifo_din;
  req_t         fifo_head;
  logic         addr_ok;

  assign addr_ok    = in_window(in_HADDR);
  assign out_HREADY = !fifo_full;
  assign fifo_push  = in_HSEL && addr_ok;
  assign fifo_pop   = (state == D_IDLE) && !fifo_empty;
  assign fifo_din   = '{write: in_HWRITE, addr: in_HADDR, wdata: in_HWDATA};

  sdram_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (in_HCLK),
    .rst   (in_HRESET),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  always_ff @(posedge in_HCLK) begin
    if (in_HRESET) begin
      state           <= D_IDLE;
      cnt             <= '0;
      out_HRDATA      <= '0;
      out_rvalid      <= 1'b0;
      out_wdone       <= 1'b0;
      out_err_addr    <= 1'b0;
      out_err_timeout <= 1'b0;
      out_ctrl_HSEL   <= 1'b0;
      out_ctrl_HWRITE <= 1'b0;
      out_ctrl_HADDR  <= '0;
      out_ctrl_HWDATA <= '0;
    end else begin
      out_rvalid   <= 1'b0;
      out_wdone    <= 1'b0;
      out_err_addr <= in_HSEL && !fifo_full && !addr_ok;
      case (state)
        D_IDLE: begin
          if (!fifo_empty) begin
            out_ctrl_HSEL   <= 1'b1;
            out_ctrl_HWRITE <= fifo_head.write;
            out_ctrl_HADDR  <= fifo_head.addr;
            out_ctrl_HWDATA <= fifo_head.wdata;
            state           <= D_ISSUE;
          end
        end
        D_ISSUE: begin
          out_ctrl_HSEL <= 1'b0;
          cnt           <= '0;
          state         <= D_WAIT;
        end
        D_WAIT: begin
          if (cnt >= CW'(CTRL_LAT - 1) && in_ctrl_HREADY) begin
            if (out_ctrl_HWRITE) begin
              out_wdone <= 1'b1;
            end else begin
              out_rvalid <= 1'b1;
              out_HRDATA <= in_ctrl_HRDATA;
            end
            state <= D_IDLE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            // Request is dropped silently apart from the sticky error flag.
            out_err_timeout <= 1'b1;
            state           <= D_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= D_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_req_queue.sv
// Directed bench for sdram_req_queue with a small controller model and response log.
module tb_sdram_req_queue;

  logic        in_HCLK = 1'b0;
  logic        in_HRESET;
  logic        in_HSEL;
  logic        in_HWRITE;
  logic [31:0] in_HADDR;
  logic [31:0] in_HWDATA;
  logic        out_HREADY;
  logic [31:0] out_HRDATA;
  logic        out_rvalid;
  logic        out_wdone;
  logic        out_err_addr;
  logic        out_err_timeout;
  logic        out_ctrl_HSEL;
  logic        out_ctrl_HWRITE;
  logic [31:0] out_ctrl_HADDR;
  logic [31:0] out_ctrl_HWDATA;
  logic        in_ctrl_HREADY;
  logic [31:0] in_ctrl_HRDATA = '0;

  int n_checks = 0;
  int n_errors = 0;

  sdram_req_queue dut (
    .in_HCLK         (in_HCLK),
    .in_HRESET       (in_HRESET),
    .in_HSEL         (in_HSEL),
    .in_HWRITE       (in_HWRITE),
    .in_HADDR        (in_HADDR),
    .in_HWDATA       (in_HWDATA),
    .out_HREADY      (out_HREADY),
    .out_HRDATA      (out_HRDATA),
    .out_rvalid      (out_rvalid),
    .out_wdone       (out_wdone),
    .out_err_addr    (out_err_addr),
    .out_err_timeout (out_err_timeout),
    .out_ctrl_HSEL   (out_ctrl_HSEL),
    .out_ctrl_HWRITE (out_ctrl_HWRITE),
    .out_ctrl_HADDR  (out_ctrl_HADDR),
    .out_ctrl_HWDATA (out_ctrl_HWDATA),
    .in_ctrl_HREADY  (in_ctrl_HREADY),
    .in_ctrl_HRDATA  (in_ctrl_HRDATA)
  );

  always #5 in_HCLK = ~in_HCLK;

  // Controller model: 16-word memory indexed by address low nibble, word 5 preloaded.
  logic [31:0] mdl_mem [16];
  logic        mdl_init = 1'b0;
  always @(posedge in_HCLK) begin
    if (!mdl_init) begin
      for (int i = 0; i < 16; i++) mdl_mem[i] <= 32'h0;
      mdl_mem[5] <= 32'hDEAD_BEEF;
      mdl_init   <= 1'b1;
    end else if (out_ctrl_HSEL) begin
      if (out_ctrl_HWRITE) mdl_mem[out_ctrl_HADDR[3:0]] <= out_ctrl_HWDATA;
      else                 in_ctrl_HRDATA <= mdl_mem[out_ctrl_HADDR[3:0]];
    end
  end

  // Response log and strobe/hold monitor, sampled on the falling edge.
  logic [32:0] resp_q [$];
  int          hsel_total = 0;
  int          hsel_viol  = 0;
  int          hold_cnt   = 0;
  int          last_hold  = 0;
  logic        in_access  = 1'b0;
  logic        prev_hsel  = 1'b0;
  logic        prev_to    = 1'b0;
  logic [31:0] acc_addr   = '0;

  always @(negedge in_HCLK) begin
    if (in_HRESET) begin
      in_access = 1'b0;
      prev_hsel = 1'b0;
      prev_to   = 1'b0;
    end else begin
      if (out_ctrl_HSEL && prev_hsel) hsel_viol++;
      if (out_ctrl_HSEL) hsel_total++;
      if (out_rvalid) resp_q.push_back({1'b1, out_HRDATA});
      if (out_wdone)  resp_q.push_back({1'b0, 32'h0});
      if (out_ctrl_HSEL) begin
        in_access = 1'b1;
        acc_addr  = out_ctrl_HADDR;
        hold_cnt  = 1;
      end else if (in_access) begin
        if (out_rvalid || out_wdone || (out_err_timeout && !prev_to)) begin
          in_access = 1'b0;
          last_hold = hold_cnt;
        end else if (out_ctrl_HADDR == acc_addr) begin
          hold_cnt++;
        end
      end
      prev_hsel = out_ctrl_HSEL;
      prev_to   = out_err_timeout;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge in_HCLK);
    #1;
  endtask

  task automatic push_req(input logic w, input logic [31:0] a, input logic [31:0] d);
    logic rdy;
    logic accepted;
    accepted  = 1'b0;
    in_HSEL   = 1'b1;
    in_HWRITE = w;
    in_HADDR  = a;
    in_HWDATA = d;
    for (int i = 0; i < 100; i++) begin
      rdy = out_HREADY;
      tick();
      if (rdy) begin
        accepted = 1'b1;
        break;
      end
    end
    if (!accepted) check_val("push_accept", 64'(accepted), 64'(1));
    in_HSEL = 1'b0;
  endtask

  task automatic wait_resp(input int n);
    for (int i = 0; i < 300; i++) begin
      if (resp_q.size() >= n) break;
      tick();
    end
    check_val("resp_count", 64'(resp_q.size()), 64'(n));
  endtask

  task automatic check_reset_outs(input string tag);
    check_val({tag, "_hready"},  64'(out_HREADY),      64'(1));
    check_val({tag, "_hrdata"},  64'(out_HRDATA),      64'(0));
    check_val({tag, "_rvalid"},  64'(out_rvalid),      64'(0));
    check_val({tag, "_wdone"},   64'(out_wdone),       64'(0));
    check_val({tag, "_erraddr"}, 64'(out_err_addr),    64'(0));
    check_val({tag, "_errto"},   64'(out_err_timeout), 64'(0));
    check_val({tag, "_csel"},    64'(out_ctrl_HSEL),   64'(0));
    check_val({tag, "_cwrite"},  64'(out_ctrl_HWRITE), 64'(0));
    check_val({tag, "_caddr"},   64'(out_ctrl_HADDR),  64'(0));
    check_val({tag, "_cwdata"},  64'(out_ctrl_HWDATA), 64'(0));
  endtask

  int hsel_base;

  initial begin
    in_HRESET      = 1'b1;
    in_HSEL        = 1'b0;
    in_HWRITE      = 1'b0;
    in_HADDR       = '0;
    in_HWDATA      = '0;
    in_ctrl_HREADY = 1'b1;
    tick();
    tick();
    check_reset_outs("rst");
    in_HRESET = 1'b0;
    tick();

    // Single read.
    push_req(1'b0, 32'h8001_4005, 32'h0);
    wait_resp(1);
    check_val("rd1_data", 64'(resp_q[0]), 64'({1'b1, 32'hDEAD_BEEF}));
    tick();
    check_val("rd1_hold", 64'(last_hold), 64'(6));
    check_val("rd1_hsel", 64'(hsel_total), 64'(1));
    resp_q.delete();

    // Write then read back, in order.
    push_req(1'b1, 32'h8000_C003, 32'h1234_5678);
    push_req(1'b0, 32'h8000_C003, 32'h0);
    wait_resp(2);
    check_val("wr_rd_0", 64'(resp_q[0]), 64'({1'b0, 32'h0}));
    check_val("wr_rd_1", 64'(resp_q[1]), 64'({1'b1, 32'h1234_5678}));
    resp_q.delete();

    // Fill the FIFO while the dispatcher is stalled on a write.
    in_ctrl_HREADY = 1'b0;
    push_req(1'b1, 32'h8000_0001, 32'h0000_0011);
    tick();
    tick();
    tick();
    push_req(1'b0, 32'h8000_0001, 32'h0);
    push_req(1'b1, 32'h8000_0002, 32'h0000_0022);
    push_req(1'b0, 32'h8000_0002, 32'h0);
    check_val("fill_hready3", 64'(out_HREADY), 64'(1));
    push_req(1'b0, 32'h8000_0005, 32'h0);
    check_val("full_hready", 64'(out_HREADY), 64'(0));
    in_HSEL   = 1'b1;
    in_HWRITE = 1'b0;
    in_HADDR  = 32'h8000_C003;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("full_hold", 64'(out_HREADY), 64'(0));
    end
    in_ctrl_HREADY = 1'b1;
    push_req(1'b0, 32'h8000_C003, 32'h0);
    wait_resp(6);
    check_val("full_r0", 64'(resp_q[0]), 64'({1'b0, 32'h0}));
    check_val("full_r1", 64'(resp_q[1]), 64'({1'b1, 32'h0000_0011}));
    check_val("full_r2", 64'(resp_q[2]), 64'({1'b0, 32'h0}));
    check_val("full_r3", 64'(resp_q[3]), 64'({1'b1, 32'h0000_0022}));
    check_val("full_r4", 64'(resp_q[4]), 64'({1'b1, 32'hDEAD_BEEF}));
    check_val("full_r5", 64'(resp_q[5]), 64'({1'b1, 32'h1234_5678}));
    for (int i = 0; i < 10; i++) tick();
    check_val("full_extra", 64'(resp_q.size()), 64'(6));
    resp_q.delete();

    // Out-of-window request.
    hsel_base = hsel_total;
    in_HSEL   = 1'b1;
    in_HWRITE = 1'b0;
    in_HADDR  = 32'h4000_0000;
    tick();
    in_HSEL = 1'b0;
    check_val("bad_erraddr", 64'(out_err_addr), 64'(1));
    check_val("bad_hready",  64'(out_HREADY), 64'(1));
    tick();
    check_val("bad_pulse_end", 64'(out_err_addr), 64'(0));
    for (int i = 0; i < 10; i++) tick();
    check_val("bad_no_hsel", 64'(hsel_total - hsel_base), 64'(0));
    check_val("bad_no_resp", 64'(resp_q.size()), 64'(0));

    // Controller never ready: timeout, then the next queued request still runs.
    in_ctrl_HREADY = 1'b0;
    push_req(1'b0, 32'h8000_0007, 32'h0);
    push_req(1'b0, 32'h8000_0002, 32'h0);
    for (int i = 0; i < 60; i++) begin
      if (out_err_timeout) break;
      tick();
    end
    check_val("to_flag", 64'(out_err_timeout), 64'(1));
    in_ctrl_HREADY = 1'b1;
    tick();
    check_val("to_wait_cycles", 64'(last_hold), 64'(16));
    wait_resp(1);
    check_val("to_next_req", 64'(resp_q[0]), 64'({1'b1, 32'h0000_0022}));
    for (int i = 0; i < 10; i++) tick();
    check_val("to_no_extra", 64'(resp_q.size()), 64'(1));
    check_val("to_sticky", 64'(out_err_timeout), 64'(1));
    resp_q.delete();

    // Reset with one request in flight and three queued.
    in_ctrl_HREADY = 1'b0;
    push_req(1'b0, 32'h8000_0001, 32'h0);
    push_req(1'b0, 32'h8000_0002, 32'h0);
    push_req(1'b1, 32'h8000_0003, 32'hAAAA_5555);
    push_req(1'b0, 32'h8000_0004, 32'h0);
    tick();
    tick();
    in_HRESET = 1'b1;
    tick();
    check_reset_outs("mid_rst");
    in_HRESET      = 1'b0;
    in_ctrl_HREADY = 1'b1;
    hsel_base      = hsel_total;
    for (int i = 0; i < 40; i++) tick();
    check_val("mid_rst_no_resp", 64'(resp_q.size()), 64'(0));
    check_val("mid_rst_no_hsel", 64'(hsel_total - hsel_base), 64'(0));
    check_val("hsel_single", 64'(hsel_viol), 64'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sdram_req_queue.md
Name: sdram_req_queue

Overview:
- Bus-side request buffer directly upstream of the SDRAM command controller.
- Accepts single-beat read/write requests from the bus master into a small in-order FIFO and dispatches them to the controller one at a time, with address and data held stable for the whole access.
- Returns read data to the master with a one-cycle valid pulse, and rejects addresses outside the SDRAM window.

Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2)
- CTRL_LAT, 5, controller busy cycles after the issue cycle (ACT, NOP1, CAS, NOP2, NOP3)
- TIMEOUT, 15, WAIT cycles without controller HREADY before the error path is taken

Ports:
- in_HCLK  in  1  clock
- in_HRESET  in  1  reset, synchronous, active-high
- in_HSEL  in  1  master request strobe
- in_HWRITE  in  1  1=write, 0=read
- in_HADDR  in  32  request address; [31:30]=2'b10 SDRAM window, [24:16] column, [15:14] bank, [13:0] row
- in_HWDATA  in  32  write data, sampled with the request
- out_HREADY  out  1  queue can accept (not full)
- out_HRDATA  out  32  read data
- out_rvalid  out  1  one-cycle pulse, out_HRDATA valid
- out_wdone  out  1  one-cycle pulse, write completed
- out_err_addr  out  1  one-cycle pulse, request rejected (bad window)
- out_err_timeout  out  1  sticky; cleared only by reset
- out_ctrl_HSEL  out  1  to controller
- out_ctrl_HWRITE  out  1  to controller
- out_ctrl_HADDR  out  32  to controller, held from ISSUE through last WAIT cycle
- out_ctrl_HWDATA  out  32  to controller, held likewise
- in_ctrl_HREADY  in  1  from controller
- in_ctrl_HRDATA  in  32  from controller

Behaviour:
- Reset (synchronous): FIFO emptied, FSM in D_IDLE.
  - out_HREADY=1; out_rvalid, out_wdone, out_err_addr, out_err_timeout = 0.
  - out_ctrl_HSEL=0, out_ctrl_HWRITE=0; out_HRDATA, out_ctrl_HADDR, out_ctrl_HWDATA = 0.
- Accept: push when in_HSEL && out_HREADY && in_HADDR[31:30]==2'b10.
  - in_HSEL && out_HREADY with any other window: no push; out_err_addr=1 next cycle.
- out_HREADY = !full, computed from registered count. No push when full, even if a pop occurs in the same cycle.
- Simultaneous push and pop when not full: count unchanged, both take effect.
- Pointers wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- Dispatcher FSM:
  - D_IDLE: if FIFO non-empty, pop the head into the hold registers and go to D_ISSUE. A request pushed into an empty FIFO is issued 1 cycle after acceptance at the earliest.
  - D_ISSUE (1 cycle): out_ctrl_HSEL=1, HWRITE/HADDR/HWDATA from the hold registers; clear the counter; go to D_WAIT.
  - D_WAIT: out_ctrl_HSEL=0, hold registers still driven, counter increments.
    - Completion: counter ≥ CTRL_LAT-1 and in_ctrl_HREADY=1.
    - Read completion: out_HRDATA <= in_ctrl_HRDATA, out_rvalid=1 next cycle.
    - Write completion: out_wdone=1 next cycle.
    - After completion go to D_IDLE. Back-to-back requests therefore issue every CTRL_LAT+2 cycles.
  - Counter reaches TIMEOUT without completion: set out_err_timeout, drop the request (no rvalid/wdone), go to D_IDLE.
- out_ctrl_HSEL is never high for more than one consecutive cycle; this prevents a controller re-trigger on return to IDLE.
- Responses are strictly in request order.
- Reset mid-operation: in-flight and queued requests are discarded with no response pulse. The controller shares the reset net.

Decomposition:
- Package sdram_pkg:
  - Dispatcher state encodings (D_IDLE, D_ISSUE, D_WAIT).
  - SDRAM window constant 2'b10.
  - Address field ranges (row, bank, column).
  - Default CTRL_LAT.
- Sub-module sdram_req_fifo: synchronous FIFO, 65-bit entry {write, addr, wdata}, DEPTH parameter; outputs full, empty, head.

Test Plan:
- Single read at 32'h8001_4005, controller model returns 32'hDEAD_BEEF → out_ctrl_HSEL high exactly 1 cycle; HADDR held 6 cycles; out_rvalid pulses once with 32'hDEAD_BEEF.
- Write 32'h1234_5678 to 32'h8000_C003, then read same address → out_wdone, then out_rvalid with 32'h1234_5678; strictly in order.
- Push 5 requests back-to-back with DEPTH=4 and dispatcher stalled → out_HREADY=0 after the 4th push; 5th held off; all 5 complete in order once it is accepted.
- Request at 32'h4000_0000 → out_err_addr pulse; no out_ctrl_HSEL; FIFO count unchanged.
- Controller model holds in_ctrl_HREADY=0 → out_err_timeout set after 15 WAIT cycles; no rvalid; next queued request still dispatched.
- Assert in_HRESET with 3 requests queued mid-WAIT → next cycle all outputs at reset values; no response pulses follow.
